// File: rtl/result_sender.sv
// result_sender: streams the top-left N x N sub-matrix of a packed 3x3 product
// to uart_tx, high byte first, over the tx_start/tx_busy handshake.
// Optional feature: define RESULT_SENDER_CSUM_EN to append an XOR checksum byte.
module result_sender #(
  parameter int unsigned MAX_DIM = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [3:0]                    matrix_size,
  input  logic [16*MAX_DIM*MAX_DIM-1:0] result,
  input  logic                          tx_busy,
  output logic [7:0]                    tx_data,
  output logic                          tx_start,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned RW = 16 * MAX_DIM * MAX_DIM;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ACK,
    DRAIN,
    FIN
  } state_t;

  state_t          state_q, state_n;
  logic [4:0]      idx_q, idx_n;
  logic [4:0]      last_q, last_n;
  logic [3:0]      row_q, row_n;
  logic [3:0]      col_q, col_n;
  logic [3:0]      n_q, n_n;
  logic [RW-1:0]   res_q, res_n;
  logic [7:0]      tx_data_n;
  logic            tx_start_n;
  logic            busy_n;
  logic            done_n;
  logic [7:0]      cur_byte;
  logic [15:0]     word;
  int unsigned     flat;
`ifdef RESULT_SENDER_CSUM_EN
  logic [7:0]      csum_q, csum_n;
`endif

  // Select the byte addressed by (row, col, idx[0]) from the snapshot.
  always_comb begin
    flat = MAX_DIM * 32'(row_q) + 32'(col_q);
    word = '0;
    for (int unsigned k = 0; k < MAX_DIM * MAX_DIM; k++) begin
      if (flat == k) word = res_q[16*k +: 16];
    end
    cur_byte = idx_q[0] ? word[7:0] : word[15:8];
  end

  // Next-state and next-output logic; all outputs are registered.
  always_comb begin
    state_n    = state_q;
    idx_n      = idx_q;
    last_n     = last_q;
    row_n      = row_q;
    col_n      = col_q;
    n_n        = n_q;
    res_n      = res_q;
    tx_data_n  = tx_data;
    tx_start_n = 1'b0;
    busy_n     = busy;
    done_n     = 1'b0;
`ifdef RESULT_SENDER_CSUM_EN
    csum_n     = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          res_n  = result;
          n_n    = matrix_size;
          idx_n  = '0;
          row_n  = '0;
          col_n  = '0;
          busy_n = 1'b1;
`ifdef RESULT_SENDER_CSUM_EN
          csum_n = '0;
          last_n = 5'(2 * 32'(matrix_size) * 32'(matrix_size));
`else
          last_n = 5'(2 * 32'(matrix_size) * 32'(matrix_size) - 1);
`endif
          if ((matrix_size == '0) || (32'(matrix_size) > MAX_DIM)) state_n = FIN;
          else                                                  state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (!tx_busy) begin
          tx_start_n = 1'b1;
`ifdef RESULT_SENDER_CSUM_EN
          // The final index carries the checksum instead of a data byte.
          if (idx_q == last_q) begin
            tx_data_n = csum_q;
          end else begin
            tx_data_n = cur_byte;
            csum_n    = csum_q ^ cur_byte;
          end
`else
          tx_data_n = cur_byte;
`endif
          state_n = ACK;
        end
      end
      ACK: begin
        if (tx_busy) state_n = DRAIN;
      end
      DRAIN: begin
        if (!tx_busy) begin
          if (idx_q == last_q) begin
            state_n = FIN;
          end else begin
            idx_n   = idx_q + 5'd1;
            state_n = ISSUE;
            // Low byte just went out: step to the next element of the N x N window.
            if (idx_q[0]) begin
              if (col_q == n_q - 4'd1) begin
                col_n = '0;
                row_n = row_q + 4'd1;
              end else begin
                col_n = col_q + 4'd1;
              end
            end
          end
        end
      end
      FIN: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      last_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      n_q      <= '0;
      res_q    <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef RESULT_SENDER_CSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      last_q   <= last_n;
      row_q    <= row_n;
      col_q    <= col_n;
      n_q      <= n_n;
      res_q    <= res_n;
      tx_data  <= tx_data_n;
      tx_start <= tx_start_n;
      busy     <= busy_n;
      done     <= done_n;
`ifdef RESULT_SENDER_CSUM_EN
      csum_q   <= csum_n;
`endif
    end
  end

endmodule

// File: tb/tb_result_sender.sv
// Bench for result_sender: table of frames plus hand-written corner sequences,
// with a simple uart_tx busy model capturing every transmitted byte.
module tb_result_sender;

`ifdef RESULT_SENDER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   matrix_size;
  logic [143:0] result;
  logic         tx_busy;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         busy;
  logic         done;

  result_sender #(.MAX_DIM(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .matrix_size(matrix_size),
    .result     (result),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   n;
    logic [143:0] res;
    logic [143:0] exp;   // expected bytes, first byte in the top octet
    logic [7:0]   nb;    // data byte count
    logic [7:0]   csum;
    logic [7:0]   blen;  // uart busy length for this frame
  } vec_t;

  vec_t tbl [6];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // uart_tx model and byte monitor
  logic [7:0]  cap [512];
  int unsigned cap_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned stable_err = 0;
  int unsigned proto_err = 0;
  int unsigned cnt = 0;
  int unsigned busy_len = 10;
  logic        hold_busy = 1'b0;
  logic [7:0]  held = '0;
  int unsigned cap_base = 0;
  int unsigned done_base = 0;

  assign tx_busy = (cnt != 0) || hold_busy;

  // Model uart_tx: accept a request, stay busy busy_len cycles, record the byte.
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt = 0;
    end else begin
      if (done) done_cnt++;
      if (tx_start) begin
        if (tx_busy) proto_err++;
        cap[cap_cnt % 512] = tx_data;
        cap_cnt++;
        held = tx_data;
        cnt  = busy_len;
      end else if (cnt != 0) begin
        cnt--;
        if (tx_data != held) stable_err++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_frame(input logic [3:0] n, input logic [143:0] res);
    cap_base    = cap_cnt;
    done_base   = done_cnt;
    start       = 1'b1;
    matrix_size = n;
    result      = res;
    tick();
    start       = 1'b0;
    matrix_size = 4'($urandom);
    result      = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
  endtask

  task automatic wait_done(input string tag, input int unsigned budget);
    int unsigned k = 0;
    while (done_cnt == done_base && k < budget) begin
      tick();
      k++;
    end
    check({tag, " done seen"}, 32'(done_cnt != done_base), 1);
    tick();
    tick();
  endtask

  task automatic wait_bytes(input string tag, input int unsigned nbytes, input int unsigned budget);
    int unsigned k = 0;
    while (cap_cnt - cap_base < nbytes && k < budget) begin
      tick();
      k++;
    end
    check({tag, " bytes reached"}, 32'(cap_cnt - cap_base >= nbytes), 1);
  endtask

  task automatic frame_check(input string tag, input vec_t v);
    int unsigned tot;
    logic [7:0]  eb;
    tot = 32'(v.nb) + ((CSUM && v.nb != 0) ? 1 : 0);
    check({tag, " byte count"}, cap_cnt - cap_base, tot);
    for (int unsigned i = 0; i < tot; i++) begin
      if (i < 32'(v.nb)) eb = v.exp[143 - 8*i -: 8];
      else               eb = v.csum;
      check($sformatf("%s byte%0d", tag, i), 32'(cap[(cap_base + i) % 512]), 32'(eb));
    end
    check({tag, " done pulses"}, done_cnt - done_base, 1);
    check({tag, " tx_data stable"}, stable_err, 0);
    check({tag, " no start while busy"}, proto_err, 0);
    check({tag, " idle after"}, {30'd0, busy, tx_start}, 0);
  endtask

  initial begin
    tbl[0] = '{4'd3,
               {16'h0009, 16'h0008, 16'h0007, 16'h0006, 16'h0005,
                16'h0004, 16'h0003, 16'h0002, 16'h0001},
               144'h0001_0002_0003_0004_0005_0006_0007_0008_0009,
               8'd18, 8'h01, 8'd10};
    tbl[1] = '{4'd2,
               {16'h2211, 16'h2111, 16'h2011, 16'h1211, 16'h1111,
                16'h1011, 16'h0211, 16'h0111, 16'h0011},
               {64'h0011_0111_1011_1111, 80'h0},
               8'd8, 8'h00, 8'd3};
    tbl[2] = '{4'd1, {{8{16'hFFFF}}, 16'hA55A}, {16'hA55A, 128'h0},
               8'd2, 8'hFF, 8'd1};
    tbl[3] = '{4'd0, {9{16'h1234}}, 144'h0, 8'd0, 8'h00, 8'd2};
    tbl[4] = '{4'd4, {9{16'h4321}}, 144'h0, 8'd0, 8'h00, 8'd2};
    tbl[5] = '{4'd2,
               {16'h0, 16'h0, 16'h0, 16'h0, 16'h5678,
                16'h1234, 16'hFFFF, 16'hBEEF, 16'hDEAD},
               {64'hDEAD_BEEF_1234_5678, 80'h0},
               8'd8, 8'h2A, 8'd1};

    rst_n       = 1'b0;
    start       = 1'b0;
    matrix_size = '0;
    result      = '0;
    repeat (3) tick();
    check("reset tx_data", 32'(tx_data), 0);
    check("reset tx_start", 32'(tx_start), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    rst_n = 1'b1;
    tick();

    // Invalid size: done two cycles after start, nothing sent
    start_frame(4'd0, tbl[3].res);
    check("n0 busy c1", 32'(busy), 1);
    check("n0 done c1", 32'(done), 0);
    tick();
    check("n0 done c2", 32'(done), 1);
    check("n0 busy c2", 32'(busy), 0);
    tick();
    check("n0 no tx", cap_cnt - cap_base, 0);

    // Start-to-first-tx_start latency
    busy_len = 1;
    start_frame(tbl[2].n, tbl[2].res);
    check("lat tx_start c1", 32'(tx_start), 0);
    check("lat busy c1", 32'(busy), 1);
    tick();
    check("lat tx_start c2", 32'(tx_start), 1);
    check("lat tx_data c2", 32'(tx_data), 32'hA5);
    wait_done("lat", 2000);
    frame_check("lat", tbl[2]);

    // Table of frames
    for (int unsigned v = 0; v < 6; v++) begin
      busy_len = 32'(tbl[v].blen);
      start_frame(tbl[v].n, tbl[v].res);
      wait_done($sformatf("vec%0d", v), 2000);
      frame_check($sformatf("vec%0d", v), tbl[v]);
    end

    // tx_busy held high before the first byte
    busy_len  = 5;
    hold_busy = 1'b1;
    start_frame(tbl[1].n, tbl[1].res);
    repeat (50) tick();
    check("stall no tx_start", cap_cnt - cap_base, 0);
    check("stall busy", 32'(busy), 1);
    hold_busy = 1'b0;
    wait_done("stall", 2000);
    frame_check("stall", tbl[1]);

    // start during a frame is ignored
    busy_len = 4;
    start_frame(tbl[0].n, tbl[0].res);
    wait_bytes("ign", 3, 500);
    start       = 1'b1;
    matrix_size = tbl[2].n;
    result      = tbl[2].res;
    tick();
    start = 1'b0;
    wait_done("ign", 2000);
    frame_check("ign", tbl[0]);

    // Reset mid-frame, then a fresh full frame
    busy_len = 3;
    start_frame(tbl[0].n, tbl[0].res);
    wait_bytes("rst", 5, 500);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst tx_start", 32'(tx_start), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst tx_data", 32'(tx_data), 0);
    repeat (5) tick();
    check("rst no done", done_cnt - done_base, 0);
    rst_n = 1'b1;
    tick();
    start_frame(tbl[0].n, tbl[0].res);
    wait_done("post", 2000);
    frame_check("post", tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
